// File: rtl/register_file.sv
// Processor register file: eight 8-bit registers, four 16-bit address registers,
// three pass-through read ports and one address port. Optional REGFILE_ZERO_R0_EN hardwires R0 to zero.
module register_file #(
    parameter logic [15:0] A4_RST = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ADDR_ASSERT_bar,
    input  logic        ADDR_LOAD_bar,
    input  logic        ADDR_INC,
    input  logic        MAIN_ASSERT_bar,
    input  logic        MAIN_LOAD_bar,
    input  logic        LHS_ASSERT_bar,
    input  logic        RHS_ASSERT_bar,
    input  logic [2:0]  ADDR_INC_SEL,
    input  logic [2:0]  ADDR_ASSERT_SEL,
    input  logic [2:0]  ADDR_LOAD_SEL,
    input  logic [2:0]  MAIN_ASSERT_SEL,
    input  logic [2:0]  LHS_ASSERT_SEL,
    input  logic [2:0]  RHS_ASSERT_SEL,
    input  logic [2:0]  MAIN_LOAD_SEL,
    input  logic [15:0] ADDR_in,
    input  logic [7:0]  MAIN_in,
    input  logic [7:0]  LHS_in,
    input  logic [7:0]  RHS_in,
    output logic [15:0] ADDR_out,
    output logic [7:0]  MAIN_out,
    output logic [7:0]  LHS_out,
    output logic [7:0]  RHS_out
);

    logic [7:0]  regs_r      [0:7];
    logic [15:0] areg_r      [0:3];
    logic [7:0]  regs_nxt_s  [0:7];
    logic [15:0] areg_nxt_s  [0:3];
    logic [7:0]  rview_s     [0:7];
    logic [15:0] addr_view_s [0:7];
    logic [15:0] inc_val_s;

    // Byte view seen by every reader; R0 may be forced to zero.
    always_comb begin
        rview_s = regs_r;
`ifdef REGFILE_ZERO_R0_EN
        rview_s[0] = 8'h00;
`endif
    end

    // 16-bit view: indices 0-3 are byte pairs {R(2p+1):R(2p)}, 4-7 are A4..A7.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            addr_view_s[p]     = {rview_s[2*p+1], rview_s[2*p]};
            addr_view_s[p + 4] = areg_r[p];
        end
    end

    // Increment result for the selected address register.
    always_comb begin
        inc_val_s = addr_view_s[ADDR_INC_SEL] + 16'd1;
`ifdef REGFILE_ZERO_R0_EN
        if (ADDR_INC_SEL == 3'd0) begin
            inc_val_s = {rview_s[1] + 8'd1, 8'h00};
        end else begin
            inc_val_s = addr_view_s[ADDR_INC_SEL] + 16'd1;
        end
`endif
    end

    // Per-byte next state: ADDR load beats MAIN load beats increment.
    always_comb begin
        regs_nxt_s = regs_r;
        for (int i = 0; i < 8; i++) begin
            if (!ADDR_LOAD_bar && !ADDR_LOAD_SEL[2] && ADDR_LOAD_SEL[1:0] == 2'(i / 2)) begin
                regs_nxt_s[i] = (i % 2 == 1) ? ADDR_in[15:8] : ADDR_in[7:0];
            end else if (!MAIN_LOAD_bar && MAIN_LOAD_SEL == 3'(i)) begin
                regs_nxt_s[i] = MAIN_in;
            end else if (ADDR_INC && !ADDR_INC_SEL[2] && ADDR_INC_SEL[1:0] == 2'(i / 2)) begin
                regs_nxt_s[i] = (i % 2 == 1) ? inc_val_s[15:8] : inc_val_s[7:0];
            end else begin
                regs_nxt_s[i] = regs_r[i];
            end
        end
`ifdef REGFILE_ZERO_R0_EN
        regs_nxt_s[0] = 8'h00;
`endif
    end

    // Address register next state: load beats increment.
    always_comb begin
        areg_nxt_s = areg_r;
        for (int j = 0; j < 4; j++) begin
            if (!ADDR_LOAD_bar && ADDR_LOAD_SEL[2] && ADDR_LOAD_SEL[1:0] == 2'(j)) begin
                areg_nxt_s[j] = ADDR_in;
            end else if (ADDR_INC && ADDR_INC_SEL[2] && ADDR_INC_SEL[1:0] == 2'(j)) begin
                areg_nxt_s[j] = inc_val_s;
            end else begin
                areg_nxt_s[j] = areg_r[j];
            end
        end
    end

    // State update with synchronous reset overriding everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < 8; k++) begin
                regs_r[k] <= 8'h00;
            end
            areg_r[0] <= A4_RST;
            areg_r[1] <= 16'h0000;
            areg_r[2] <= 16'h0000;
            areg_r[3] <= 16'h0000;
        end else begin
            regs_r <= regs_nxt_s;
            areg_r <= areg_nxt_s;
        end
    end

    assign MAIN_out = !MAIN_ASSERT_bar ? rview_s[MAIN_ASSERT_SEL] : MAIN_in;
    assign LHS_out  = !LHS_ASSERT_bar  ? rview_s[LHS_ASSERT_SEL]  : LHS_in;
    assign RHS_out  = !RHS_ASSERT_bar  ? rview_s[RHS_ASSERT_SEL]  : RHS_in;
    assign ADDR_out = !ADDR_ASSERT_bar ? addr_view_s[ADDR_ASSERT_SEL] : ADDR_in;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default build and REGFILE_ZERO_R0_EN).
module tb_register_file;

    localparam logic [15:0] A4_RST_TB = 16'hC000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ADDR_ASSERT_bar, ADDR_LOAD_bar, ADDR_INC;
    logic        MAIN_ASSERT_bar, MAIN_LOAD_bar, LHS_ASSERT_bar, RHS_ASSERT_bar;
    logic [2:0]  ADDR_INC_SEL, ADDR_ASSERT_SEL, ADDR_LOAD_SEL;
    logic [2:0]  MAIN_ASSERT_SEL, LHS_ASSERT_SEL, RHS_ASSERT_SEL, MAIN_LOAD_SEL;
    logic [15:0] ADDR_in, ADDR_out;
    logic [7:0]  MAIN_in, LHS_in, RHS_in, MAIN_out, LHS_out, RHS_out;

    int vec_cnt = 0;
    int err_cnt = 0;

    register_file #(.A4_RST(A4_RST_TB)) dut (
        .CLK(CLK), .RST(RST),
        .ADDR_ASSERT_bar(ADDR_ASSERT_bar), .ADDR_LOAD_bar(ADDR_LOAD_bar), .ADDR_INC(ADDR_INC),
        .MAIN_ASSERT_bar(MAIN_ASSERT_bar), .MAIN_LOAD_bar(MAIN_LOAD_bar),
        .LHS_ASSERT_bar(LHS_ASSERT_bar), .RHS_ASSERT_bar(RHS_ASSERT_bar),
        .ADDR_INC_SEL(ADDR_INC_SEL), .ADDR_ASSERT_SEL(ADDR_ASSERT_SEL), .ADDR_LOAD_SEL(ADDR_LOAD_SEL),
        .MAIN_ASSERT_SEL(MAIN_ASSERT_SEL), .LHS_ASSERT_SEL(LHS_ASSERT_SEL),
        .RHS_ASSERT_SEL(RHS_ASSERT_SEL), .MAIN_LOAD_SEL(MAIN_LOAD_SEL),
        .ADDR_in(ADDR_in), .MAIN_in(MAIN_in), .LHS_in(LHS_in), .RHS_in(RHS_in),
        .ADDR_out(ADDR_out), .MAIN_out(MAIN_out), .LHS_out(LHS_out), .RHS_out(RHS_out)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        RST = 1'b0;
        ADDR_ASSERT_bar = 1'b1; ADDR_LOAD_bar = 1'b1; ADDR_INC = 1'b0;
        MAIN_ASSERT_bar = 1'b1; MAIN_LOAD_bar = 1'b1;
        LHS_ASSERT_bar = 1'b1;  RHS_ASSERT_bar = 1'b1;
        ADDR_INC_SEL = 3'd0; ADDR_ASSERT_SEL = 3'd0; ADDR_LOAD_SEL = 3'd0;
        MAIN_ASSERT_SEL = 3'd0; LHS_ASSERT_SEL = 3'd0; RHS_ASSERT_SEL = 3'd0; MAIN_LOAD_SEL = 3'd0;
        ADDR_in = 16'h0000; MAIN_in = 8'h00; LHS_in = 8'h00; RHS_in = 8'h00;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        idle();
    endtask

    task automatic rd_main(input logic [2:0] sel, input string tag, input logic [7:0] exp);
        MAIN_ASSERT_bar = 1'b0; MAIN_ASSERT_SEL = sel; #1;
        check_val(tag, {8'h00, MAIN_out}, {8'h00, exp});
        MAIN_ASSERT_bar = 1'b1;
    endtask

    task automatic rd_addr(input logic [2:0] sel, input string tag, input logic [15:0] exp);
        ADDR_ASSERT_bar = 1'b0; ADDR_ASSERT_SEL = sel; #1;
        check_val(tag, ADDR_out, exp);
        ADDR_ASSERT_bar = 1'b1;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        tick();

        for (int s = 0; s < 8; s++) begin
            rd_main(3'(s), $sformatf("rst_r%0d", s), 8'h00);
            rd_addr(3'(s), $sformatf("rst_a%0d", s), (s == 4) ? A4_RST_TB : 16'h0000);
        end

        MAIN_in = 8'h5A; LHS_in = 8'hC3; RHS_in = 8'h96; ADDR_in = 16'h1234; #1;
        check_val("pass_main", {8'h00, MAIN_out}, 16'h005A);
        check_val("pass_lhs",  {8'h00, LHS_out},  16'h00C3);
        check_val("pass_rhs",  {8'h00, RHS_out},  16'h0096);
        check_val("pass_addr", ADDR_out, 16'h1234);

        // R3 load; the bus shows the old value until the edge
        MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd3; MAIN_in = 8'hA5;
        MAIN_ASSERT_bar = 1'b0; MAIN_ASSERT_SEL = 3'd3; #1;
        check_val("pre_edge_r3", {8'h00, MAIN_out}, 16'h0000);
        tick();
        MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd2; MAIN_in = 8'h3C;
        tick();
        LHS_ASSERT_bar = 1'b0; LHS_ASSERT_SEL = 3'd3;
        RHS_ASSERT_bar = 1'b0; RHS_ASSERT_SEL = 3'd2;
        ADDR_ASSERT_bar = 1'b0; ADDR_ASSERT_SEL = 3'd1; #1;
        check_val("lhs_r3", {8'h00, LHS_out}, 16'h00A5);
        check_val("rhs_r2", {8'h00, RHS_out}, 16'h003C);
        check_val("pair1", ADDR_out, 16'hA53C);
        idle();

        ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 3'd6; ADDR_in = 16'hFFFF;
        tick();
        rd_addr(3'd6, "a6_load", 16'hFFFF);
        ADDR_INC = 1'b1; ADDR_INC_SEL = 3'd6;
        tick();
        rd_addr(3'd6, "a6_wrap", 16'h0000);

        ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 3'd2; ADDR_in = 16'h00FF;
        tick();
        ADDR_INC = 1'b1; ADDR_INC_SEL = 3'd2;
        tick();
        rd_main(3'd5, "pair2_hi", 8'h01);
        rd_main(3'd4, "pair2_lo", 8'h00);
        rd_addr(3'd2, "pair2", 16'h0100);

        ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 3'd5; ADDR_in = 16'h1000;
        ADDR_INC = 1'b1; ADDR_INC_SEL = 3'd5;
        tick();
        rd_addr(3'd5, "load_over_inc", 16'h1000);

        ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 3'd0; ADDR_in = 16'h0010;
        tick();
        MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd0; MAIN_in = 8'h77;
        ADDR_INC = 1'b1; ADDR_INC_SEL = 3'd0;
        tick();
`ifdef REGFILE_ZERO_R0_EN
        rd_main(3'd0, "main_over_inc_r0", 8'h00);
        rd_main(3'd1, "main_over_inc_r1", 8'h01);
`else
        rd_main(3'd0, "main_over_inc_r0", 8'h77);
        rd_main(3'd1, "main_over_inc_r1", 8'h00);
`endif

        // Three non-overlapping targets in one edge
        MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd6; MAIN_in = 8'h42;
        ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 3'd7; ADDR_in = 16'h5555;
        ADDR_INC = 1'b1; ADDR_INC_SEL = 3'd4;
        tick();
        rd_main(3'd6, "multi_r6", 8'h42);
        rd_addr(3'd7, "multi_a7", 16'h5555);
        rd_addr(3'd4, "multi_a4", A4_RST_TB + 16'd1);

        RST = 1'b1;
        MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd7; MAIN_in = 8'hEE;
        ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 3'd7; ADDR_in = 16'hBEEF;
        tick();
        rd_main(3'd7, "midrst_r7", 8'h00);
        rd_addr(3'd7, "midrst_a7", 16'h0000);
        rd_addr(3'd4, "midrst_a4", A4_RST_TB);
        rd_main(3'd3, "midrst_r3", 8'h00);

        MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd0; MAIN_in = 8'hFF;
        tick();
        ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 3'd0; ADDR_in = 16'hAB11;
        tick();
`ifdef REGFILE_ZERO_R0_EN
        rd_main(3'd0, "zero_r0", 8'h00);
        rd_addr(3'd0, "zero_pair0", 16'hAB00);
`else
        rd_main(3'd0, "r0_plain", 8'h11);
        rd_addr(3'd0, "pair0_plain", 16'hAB11);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
